// File: rtl/execute_stage_mc.sv
// Execute stage: operand forwarding, ALU, branch resolution, E->M register,
// and an iterative multi-cycle MUL/MULHU unit (plus DIVU/REMU when the
// EXEC_DIV_EN macro is defined) that stalls upstream while it runs.
module execute_stage_mc #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ValidE,
  input  logic               FlushE,
  input  logic               RegWriteE,
  input  logic               MemWriteE,
  input  logic               ResultSrcE,
  input  logic               BranchE,
  input  logic               JumpE,
  input  logic [2:0]         BrFunctE,
  input  logic               ALUSrcE,
  input  logic [3:0]         ALUControlE,
  input  logic [XLEN-1:0]    RD1_E,
  input  logic [XLEN-1:0]    RD2_E,
  input  logic [XLEN-1:0]    Imm_Ext_E,
  input  logic [RADDR_W-1:0] RD_E,
  input  logic [XLEN-1:0]    PCE,
  input  logic [XLEN-1:0]    PCPlus4E,
  input  logic [XLEN-1:0]    ResultW,
  input  logic [1:0]         ForwardA_E,
  input  logic [1:0]         ForwardB_E,
  output logic               StallE,
  output logic               PCSrcE,
  output logic [XLEN-1:0]    PCTargetE,
  output logic               ValidM,
  output logic               RegWriteM,
  output logic               MemWriteM,
  output logic               ResultSrcM,
  output logic [RADDR_W-1:0] RD_M,
  output logic [XLEN-1:0]    PCPlus4M,
  output logic [XLEN-1:0]    WriteDataM,
  output logic [XLEN-1:0]    ALU_ResultM
);

  localparam int unsigned SH_W  = $clog2(XLEN);
  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_SLT   = 4'h5;
  localparam logic [3:0] OP_SLTU  = 4'h6;
  localparam logic [3:0] OP_SLL   = 4'h7;
  localparam logic [3:0] OP_SRL   = 4'h8;
  localparam logic [3:0] OP_SRA   = 4'h9;
  localparam logic [3:0] OP_MUL   = 4'hA;
  localparam logic [3:0] OP_MULHU = 4'hB;
`ifdef EXEC_DIV_EN
  localparam logic [3:0] OP_DIVU  = 4'hC;
  localparam logic [3:0] OP_REMU  = 4'hD;
`endif

  // Operand and ALU signals
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b_fwd;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_res;
  logic [SH_W-1:0] shamt;
  logic            br_cond;
  logic            is_mc_op;

  // Multi-cycle unit state
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic [XLEN-1:0]  opb_q, opb_d;
  logic             hi_sel_q, hi_sel_d;
  logic             stall_c;
  logic             mc_done_c;
  logic [XLEN-1:0]  mc_result;
  logic [XLEN:0]    mul_sum;
`ifdef EXEC_DIV_EN
  logic             is_div_q, is_div_d;
  logic [XLEN:0]    div_shift;
  logic             div_ge;
  logic [XLEN-1:0]  div_diff;
`endif

  // E->M pipeline register
  logic               valid_m_q, valid_m_d;
  logic               reg_write_m_q, reg_write_m_d;
  logic               mem_write_m_q, mem_write_m_d;
  logic               result_src_m_q, result_src_m_d;
  logic [RADDR_W-1:0] rd_m_q, rd_m_d;
  logic [XLEN-1:0]    pc_plus4_m_q, pc_plus4_m_d;
  logic [XLEN-1:0]    write_data_m_q, write_data_m_d;
  logic [XLEN-1:0]    alu_result_m_q, alu_result_m_d;

  // Forwarding muxes for both operands, then the immediate select
  always_comb begin
    src_a = RD1_E;
    case (ForwardA_E)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = alu_result_m_q;
      default: src_a = RD1_E;
    endcase
    src_b_fwd = RD2_E;
    case (ForwardB_E)
      2'b01:   src_b_fwd = ResultW;
      2'b10:   src_b_fwd = alu_result_m_q;
      default: src_b_fwd = RD2_E;
    endcase
    src_b = ALUSrcE ? Imm_Ext_E : src_b_fwd;
  end

  assign shamt = src_b[SH_W-1:0];

  // Single-cycle ALU; multi-cycle and reserved codes give 0 here
  always_comb begin
    alu_res = '0;
    case (ALUControlE)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_SLT:  alu_res = XLEN'($signed(src_a) < $signed(src_b));
      OP_SLTU: alu_res = XLEN'(src_a < src_b);
      OP_SLL:  alu_res = src_a << shamt;
      OP_SRL:  alu_res = src_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(src_a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // Branch condition compares forwarded operands, ignoring the immediate mux
  always_comb begin
    br_cond = 1'b0;
    case (BrFunctE)
      3'b000:  br_cond = (src_a == src_b_fwd);
      3'b001:  br_cond = (src_a != src_b_fwd);
      3'b100:  br_cond = ($signed(src_a) <  $signed(src_b_fwd));
      3'b101:  br_cond = ($signed(src_a) >= $signed(src_b_fwd));
      3'b110:  br_cond = (src_a <  src_b_fwd);
      3'b111:  br_cond = (src_a >= src_b_fwd);
      default: br_cond = 1'b0;
    endcase
  end

  assign PCSrcE    = ValidE & ~FlushE & (JumpE | (BranchE & br_cond));
  assign PCTargetE = PCE + Imm_Ext_E;

`ifdef EXEC_DIV_EN
  assign is_mc_op = (ALUControlE == OP_MUL)  || (ALUControlE == OP_MULHU) ||
                    (ALUControlE == OP_DIVU) || (ALUControlE == OP_REMU);
`else
  assign is_mc_op = (ALUControlE == OP_MUL)  || (ALUControlE == OP_MULHU);
`endif

  // Shift-add step: {hi,lo} holds partial product above remaining multiplier bits
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});

`ifdef EXEC_DIV_EN
  // Restoring divide step: hi is partial remainder, lo shifts dividend out / quotient in
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_ge    = (div_shift >= {1'b0, opb_q});
  assign div_diff  = div_shift[XLEN-1:0] - opb_q;
`endif

  // Low half is product-low or quotient, high half is product-high or remainder
  assign mc_result = hi_sel_q ? hi_q : lo_q;

  // Multi-cycle FSM next state, stall generation and datapath step
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    hi_sel_d  = hi_sel_q;
`ifdef EXEC_DIV_EN
    is_div_d  = is_div_q;
`endif
    stall_c   = 1'b0;
    mc_done_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ValidE && is_mc_op) begin
          stall_c  = 1'b1;
          state_d  = ST_BUSY;
          cnt_d    = '0;
          hi_d     = '0;
          lo_d     = src_a;
          opb_d    = src_b;
          hi_sel_d = ALUControlE[0];
`ifdef EXEC_DIV_EN
          is_div_d = ALUControlE[2];
`endif
        end
      end
      ST_BUSY: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
`ifdef EXEC_DIV_EN
        if (is_div_q) begin
          hi_d = div_ge ? div_diff : div_shift[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], div_ge};
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
`else
        hi_d = mul_sum[XLEN:1];
        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
`endif
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        mc_done_c = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush kills anything in flight, including a finished result
    if (FlushE) begin
      state_d   = ST_IDLE;
      stall_c   = 1'b0;
      mc_done_c = 1'b0;
    end
  end

  assign StallE = stall_c;

  // Multi-cycle FSM and operand registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      hi_sel_q <= 1'b0;
`ifdef EXEC_DIV_EN
      is_div_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      hi_sel_q <= hi_sel_d;
`ifdef EXEC_DIV_EN
      is_div_q <= is_div_d;
`endif
    end
  end

  // E->M load: real instruction when not stalled/flushed, bubble otherwise
  always_comb begin
    valid_m_d      = 1'b0;
    reg_write_m_d  = 1'b0;
    mem_write_m_d  = 1'b0;
    result_src_m_d = result_src_m_q;
    rd_m_d         = rd_m_q;
    pc_plus4_m_d   = pc_plus4_m_q;
    write_data_m_d = write_data_m_q;
    alu_result_m_d = alu_result_m_q;
    if (ValidE && !FlushE && !stall_c) begin
      valid_m_d      = 1'b1;
      reg_write_m_d  = RegWriteE;
      mem_write_m_d  = MemWriteE;
      result_src_m_d = ResultSrcE;
      rd_m_d         = RD_E;
      pc_plus4_m_d   = PCPlus4E;
      write_data_m_d = src_b_fwd;
      alu_result_m_d = mc_done_c ? mc_result : alu_res;
    end
  end

  // E->M pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_m_q      <= 1'b0;
      reg_write_m_q  <= 1'b0;
      mem_write_m_q  <= 1'b0;
      result_src_m_q <= 1'b0;
      rd_m_q         <= '0;
      pc_plus4_m_q   <= '0;
      write_data_m_q <= '0;
      alu_result_m_q <= '0;
    end else begin
      valid_m_q      <= valid_m_d;
      reg_write_m_q  <= reg_write_m_d;
      mem_write_m_q  <= mem_write_m_d;
      result_src_m_q <= result_src_m_d;
      rd_m_q         <= rd_m_d;
      pc_plus4_m_q   <= pc_plus4_m_d;
      write_data_m_q <= write_data_m_d;
      alu_result_m_q <= alu_result_m_d;
    end
  end

  assign ValidM      = valid_m_q;
  assign RegWriteM   = reg_write_m_q;
  assign MemWriteM   = mem_write_m_q;
  assign ResultSrcM  = result_src_m_q;
  assign RD_M        = rd_m_q;
  assign PCPlus4M    = pc_plus4_m_q;
  assign WriteDataM  = write_data_m_q;
  assign ALU_ResultM = alu_result_m_q;

endmodule

// File: tb/tb_execute_stage_mc.sv
// Self-checking bench for execute_stage_mc: randomized stimulus against an
// arithmetic reference model (64-bit products, native divide/compare).
module tb_execute_stage_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidE, FlushE, RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE;
  logic [2:0]  BrFunctE;
  logic        ALUSrcE;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        StallE, PCSrcE;
  logic [31:0] PCTargetE;
  logic        ValidM, RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_alu;   // expected ALU_ResultM held by the model

  always #5 clk = ~clk;

  execute_stage_mc #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst), .ValidE(ValidE), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .BranchE(BranchE), .JumpE(JumpE), .BrFunctE(BrFunctE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
    .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ResultW(ResultW),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .StallE(StallE),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ValidM(ValidM), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M),
    .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h6: return (a < b) ? 32'd1 : 32'd0;
      4'h7: return a << b[4:0];
      4'h8: return a >> b[4:0];
      4'h9: return $unsigned($signed(a) >>> b[4:0]);
      4'hA: return p[31:0];
      4'hB: return p[63:32];
`ifdef EXEC_DIV_EN
      4'hC: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      4'hD: return (b == 32'd0) ? a : a % b;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_is_mc(input logic [3:0] op);
`ifdef EXEC_DIV_EN
    return (op >= 4'hA) && (op <= 4'hD);
`else
    return (op == 4'hA) || (op == 4'hB);
`endif
  endfunction

  function automatic logic ref_br(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) <  $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rd,
                                      input logic [31:0] rw, input logic [31:0] am);
    return (sel == 2'b01) ? rw : (sel == 2'b10) ? am : rd;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ValidE = 0; FlushE = 0; RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0;
    BranchE = 0; JumpE = 0; BrFunctE = 0; ALUSrcE = 0; ALUControlE = 0;
    RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0; ResultW = 0;
    RD_E = 0; ForwardA_E = 0; ForwardB_E = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    #2;
    checks++;
    if ({ValidM, RegWriteM, MemWriteM, ResultSrcM, StallE} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000",
                         {ValidM, RegWriteM, MemWriteM, ResultSrcM, StallE});
    end
    checks++;
    if ({RD_M, PCPlus4M, WriteDataM, ALU_ResultM} !== '0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h exp 0", RD_M, PCPlus4M, WriteDataM, ALU_ResultM);
    end
    step(); step();
    rst = 1'b1;
    m_alu = 32'd0;
    step();
  endtask

  // Drive one single-cycle instruction, step, check M-stage contents
  task automatic issue_single(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] rw,
                              input logic alusrc, input logic [31:0] imm, input logic v,
                              input logic fl, input string name);
    logic [31:0] sa, sbf, sb, exp_r;
    logic rwe, mwe, rse; logic [4:0] rd; logic [31:0] pc4;
    rwe = 1'($urandom); mwe = 1'($urandom); rse = 1'($urandom);
    rd = 5'($urandom); pc4 = $urandom;
    sa = fwd(fa, a, rw, m_alu); sbf = fwd(fb, b, rw, m_alu);
    sb = alusrc ? imm : sbf;
    exp_r = ref_alu(op, sa, sb);
    ValidE = v; FlushE = fl; ALUControlE = op; RD1_E = a; RD2_E = b; ForwardA_E = fa;
    ForwardB_E = fb; ResultW = rw; ALUSrcE = alusrc; Imm_Ext_E = imm; RegWriteE = rwe;
    MemWriteE = mwe; ResultSrcE = rse; RD_E = rd; PCPlus4E = pc4; BranchE = 0; JumpE = 0;
    #1;
    checks++;
    if (StallE !== 1'b0) begin errors++; $display("FAIL %s stall got %b exp 0", name, StallE); end
    step();
    if (v && !fl) begin
      checks++;
      if ({ValidM, RegWriteM, MemWriteM, ResultSrcM, RD_M} !== {1'b1, rwe, mwe, rse, rd}) begin
        errors++; $display("FAIL %s ctrl got %b exp %b", name, {ValidM, RegWriteM, MemWriteM, ResultSrcM, RD_M},
                           {1'b1, rwe, mwe, rse, rd});
      end
      checks++;
      if ({ALU_ResultM, WriteDataM, PCPlus4M} !== {exp_r, sbf, pc4}) begin
        errors++; $display("FAIL %s data got %h %h %h exp %h %h %h", name, ALU_ResultM, WriteDataM,
                           PCPlus4M, exp_r, sbf, pc4);
      end
      m_alu = exp_r;
    end else begin
      checks++;
      if ({ValidM, RegWriteM, MemWriteM, ALU_ResultM} !== {3'b000, m_alu}) begin
        errors++; $display("FAIL %s bubble got %b %h exp 000 %h", name, {ValidM, RegWriteM, MemWriteM},
                           ALU_ResultM, m_alu);
      end
    end
    ValidE = 0; FlushE = 0;
  endtask

  task automatic test_directed_alu();
    issue_single(4'h0, 32'd5, 32'd7, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, "add_5_7");
    checks++;
    if (ALU_ResultM !== 32'd12) begin errors++; $display("FAIL add_12 got %h exp 0000000c", ALU_ResultM); end
    issue_single(4'h0, 32'h10, 32'd0, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, "add_10");
    issue_single(4'h1, 32'hDEAD, 32'd1, 2'b10, 2'b00, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, "sub_fwdm");
    checks++;
    if (ALU_ResultM !== 32'hF) begin errors++; $display("FAIL sub_fwd got %h exp 0000000f", ALU_ResultM); end
    issue_single(4'h2, 32'h7, 32'hFF, 2'b00, 2'b01, 32'd3, 1'b0, 32'd0, 1'b1, 1'b0, "and_fwdw");
    checks++;
    if (ALU_ResultM !== 32'd3) begin errors++; $display("FAIL and_fwd got %h exp 00000003", ALU_ResultM); end
  endtask

  task automatic test_alu_random();
    for (int i = 0; i < 60; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (ref_is_mc(op)) op = 4'($urandom_range(0, 9));
      issue_single(op, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                   2'($urandom), 2'($urandom), $urandom, 1'($urandom), $urandom,
                   ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), "alu_rand");
    end
  endtask

  task automatic check_branch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                              input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] rw,
                              input logic br, input logic jmp, input logic v, input logic fl,
                              input logic alusrc, input logic [31:0] pc, input logic [31:0] imm);
    logic exp_src;
    exp_src = v & ~fl & (jmp | (br & ref_br(f, fwd(fa, a, rw, m_alu), fwd(fb, b, rw, m_alu))));
    ValidE = v; FlushE = fl; BranchE = br; JumpE = jmp; BrFunctE = f; RD1_E = a; RD2_E = b;
    ForwardA_E = fa; ForwardB_E = fb; ResultW = rw; ALUSrcE = alusrc; Imm_Ext_E = imm; PCE = pc;
    ALUControlE = 4'h0; RegWriteE = 0; MemWriteE = 0;
    #1;
    checks++;
    if ({PCSrcE, PCTargetE} !== {exp_src, pc + imm}) begin
      errors++; $display("FAIL branch f=%0d got %b %h exp %b %h", f, PCSrcE, PCTargetE, exp_src, pc + imm);
    end
    step();
    if (v && !fl) m_alu = fwd(fa, a, rw, m_alu) + (alusrc ? imm : fwd(fb, b, rw, m_alu));
    ValidE = 0; FlushE = 0; BranchE = 0; JumpE = 0;
  endtask

  task automatic test_branch();
    check_branch(3'd4, 32'hFFFF_FFFF, 32'd1, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0, 32'h100, 32'h20);
    check_branch(3'd6, 32'hFFFF_FFFF, 32'd1, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0, 32'h100, 32'h20);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = $urandom;
      check_branch(3'($urandom), a, ($urandom_range(0, 2) == 0) ? a : $urandom, 2'($urandom), 2'($urandom),
                   $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 5) != 0), ($urandom_range(0, 6) == 0), 1'($urandom),
                   $urandom, $urandom);
    end
  endtask

  // Issue one multi-cycle op; A comes via ResultW forwarding, which is scrambled while stalled
  task automatic run_mc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_r; logic [4:0] rd; int stall_cnt;
    exp_r = ref_alu(op, a, b); rd = 5'($urandom);
    ValidE = 1; FlushE = 0; ALUControlE = op; ForwardA_E = 2'b01; ResultW = a; RD1_E = $urandom;
    ForwardB_E = 2'b00; RD2_E = b; ALUSrcE = 0; RegWriteE = 1; MemWriteE = 0; ResultSrcE = 0;
    RD_E = rd; PCPlus4E = 32'h44;
    #1;
    checks++;
    if (StallE !== 1'b1) begin errors++; $display("FAIL mc_issue_stall op=%h got %b exp 1", op, StallE); end
    stall_cnt = 1;
    while (1) begin
      step();
      ResultW = $urandom;
      #1;
      checks++;
      if (ValidM !== 1'b0) begin errors++; $display("FAIL mc_busy_validm op=%h got %b exp 0", op, ValidM); end
      if (StallE !== 1'b1) break;
      stall_cnt++;
      if (stall_cnt > 100) break;
    end
    checks++;
    if (stall_cnt != 33) begin errors++; $display("FAIL mc_stall_len op=%h got %0d exp 33", op, stall_cnt); end
    step();
    checks++;
    if ({ValidM, RegWriteM, RD_M, ALU_ResultM, WriteDataM} !== {1'b1, 1'b1, rd, exp_r, b}) begin
      errors++; $display("FAIL mc_result op=%h a=%h b=%h got %b %h %h exp 1 %h %h", op, a, b, ValidM,
                         ALU_ResultM, WriteDataM, exp_r, b);
    end
    m_alu = exp_r;
    ValidE = 0;
  endtask

  task automatic test_mul();
    run_mc(4'hA, 32'h10000, 32'h10000);
    checks++;
    if (ALU_ResultM !== 32'd0) begin errors++; $display("FAIL mul_spec got %h exp 0", ALU_ResultM); end
    run_mc(4'hB, 32'h10000, 32'h10000);
    checks++;
    if (ALU_ResultM !== 32'd1) begin errors++; $display("FAIL mulhu_spec got %h exp 1", ALU_ResultM); end
    run_mc(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (ALU_ResultM !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu_max got %h exp fffffffe", ALU_ResultM); end
    for (int i = 0; i < 4; i++) run_mc(4'($urandom_range(10, 11)), $urandom, $urandom);
  endtask

  task automatic test_div();
`ifdef EXEC_DIV_EN
    run_mc(4'hC, 32'd100, 32'd7);
    checks++;
    if (ALU_ResultM !== 32'd14) begin errors++; $display("FAIL divu_spec got %h exp 0000000e", ALU_ResultM); end
    run_mc(4'hD, 32'd100, 32'd7);
    checks++;
    if (ALU_ResultM !== 32'd2) begin errors++; $display("FAIL remu_spec got %h exp 00000002", ALU_ResultM); end
    run_mc(4'hC, 32'd5, 32'd0);
    checks++;
    if (ALU_ResultM !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero got %h exp ffffffff", ALU_ResultM); end
    run_mc(4'hD, 32'd5, 32'd0);
    for (int i = 0; i < 4; i++)
      run_mc(4'($urandom_range(12, 13)), $urandom, ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300)));
`else
    issue_single(4'hC, 32'd100, 32'd7, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, "divu_nodiv");
    checks++;
    if (ALU_ResultM !== 32'd0) begin errors++; $display("FAIL divu_nodiv got %h exp 0", ALU_ResultM); end
    issue_single(4'hD, 32'd100, 32'd7, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, "remu_nodiv");
`endif
  endtask

  task automatic test_flush();
    ValidE = 1; ALUControlE = 4'hA; RD1_E = 32'd3; RD2_E = 32'd5; ForwardA_E = 0; ForwardB_E = 0;
    ALUSrcE = 0; RegWriteE = 1;
    #1;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (StallE !== 1'b1) begin errors++; $display("FAIL flush_prebusy got %b exp 1", StallE); end
    FlushE = 1; JumpE = 1;
    #1;
    checks++;
    if ({StallE, PCSrcE} !== 2'b00) begin errors++; $display("FAIL flush_comb got %b exp 00", {StallE, PCSrcE}); end
    step();
    FlushE = 0; JumpE = 0; ValidE = 0;
    checks++;
    if ({ValidM, ALU_ResultM} !== {1'b0, m_alu}) begin
      errors++; $display("FAIL flush_bubble got %b %h exp 0 %h", ValidM, ALU_ResultM, m_alu);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if ({StallE, ValidM} !== 2'b00) begin
        errors++; $display("FAIL flush_idle cyc=%0d got %b exp 00", i, {StallE, ValidM});
        break;
      end
    end
    run_mc(4'hA, 32'd3, 32'd5);
  endtask

  task automatic test_reset_mid_busy();
    ValidE = 1; ALUControlE = 4'hB; RD1_E = $urandom; RD2_E = $urandom; ForwardA_E = 0; ForwardB_E = 0;
    RegWriteE = 1; MemWriteE = 1;
    #1;
    for (int i = 0; i < 6; i++) step();
    rst = 0; ValidE = 0;
    #1;
    checks++;
    if ({ValidM, RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM, StallE} !== '0) begin
      errors++; $display("FAIL rst_busy got %b %h %h exp 0", {ValidM, RegWriteM, MemWriteM, StallE},
                         ALU_ResultM, WriteDataM);
    end
    m_alu = 0;
    step(); step();
    rst = 1;
    for (int i = 0; i < 36; i++) begin
      step();
      checks++;
      if ({StallE, ValidM, ALU_ResultM} !== {2'b00, 32'd0}) begin
        errors++; $display("FAIL rst_busy_after cyc=%0d got %b %h exp 00 0", i, {StallE, ValidM}, ALU_ResultM);
        break;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed_alu();
    test_alu_random();
    test_branch();
    test_mul();
    test_div();
    test_flush();
    test_reset_mid_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
